lsu_wb_master: RTL and testbench
================================

LSU_WB_MASTER -- requirements
Module: lsu_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning consecutive BUS-state cycles without ack_i before abort (legal range 1..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req_i  input  1  core memory request; held high by core until done_o.
REQ-005 SHALL have port we_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have port addr_i  input  32  byte address.
REQ-007 SHALL have port wdata_i  input  32  store data, right-aligned.
REQ-008 SHALL have port size_i  input  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port unsigned_i  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-010 SHALL have port stall_o  output  1  core must hold pipeline.
REQ-011 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata_o  output  32  extended load data, valid while done_o is high.
REQ-013 SHALL have port misalign_o  output  1  misaligned access flag, valid with done_o.
REQ-014 SHALL have port timeout_o  output  1  bus timeout flag, valid with done_o.
REQ-015 SHALL have Wishbone master ports cyc_o, stb_o, we_o (1 each), adr_o (32), sel_o (4), dat_o (32) as outputs, and dat_i (32), ack_i (1) as inputs.

Function
REQ-016 SHALL implement FSM states IDLE, BUS, RDATA, DONE.
REQ-017 IDLE: on req_i high and aligned, SHALL register addr, wdata, size, we and unsigned, then enter BUS; on req_i high and misaligned, SHALL enter DONE with misalign set and no bus cycle.
REQ-018 Misaligned SHALL mean half with addr_i[0]=1, or word with addr_i[1:0]!=0.
REQ-019 BUS: cyc_o=stb_o=1; ack_i with we SHALL go to DONE; ack_i without we SHALL go to RDATA.
REQ-020 BUS: the counter SHALL clear on BUS entry and increment per BUS cycle with ack_i low; on reaching TIMEOUT, SHALL go to DONE with timeout set; ack_i in the same cycle takes priority over timeout.
REQ-021 RDATA: SHALL capture dat_i (slave data is registered, valid the cycle after ack) into rdata_o, then enter DONE; cyc_o=stb_o=0 in RDATA.
REQ-022 DONE: done_o=1 for exactly one cycle, then unconditionally IDLE; a request is never accepted in DONE.
REQ-023 stall_o SHALL be (IDLE and req_i) or BUS or RDATA; low in DONE.
REQ-024 adr_o SHALL be {addr[31:2],2'b00}; we_o equals the registered we; all Wishbone outputs SHALL be registered or derived from the state only.
REQ-025 sel_o SHALL be 4'b0001<<addr[1:0] for byte, 4'b0011<<{addr[1],1'b0} for half, and 4'b1111 for word; sel_o is 0 outside BUS.
REQ-026 dat_o SHALL replicate the byte to all 4 lanes, the half to both halves, and the word as-is.
REQ-027 Load extraction SHALL select the lane by addr[1:0] (byte) or addr[1] (half) and extend per unsigned; word loads pass through.
REQ-028 Latency from req_i at cycle T: store done_o at T+2 and load done_o at T+3 with a zero-wait slave; misaligned done_o at T+1.
REQ-029 misalign_o, timeout_o and rdata_o SHALL hold until the next request is accepted; on timeout, rdata_o SHALL be 0.

Reset
REQ-030 reset_n low SHALL immediately force IDLE and clear cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, rdata_o, done_o, stall_o, misalign_o, timeout_o and the counter, including mid-transaction.

Verification
REQ-031 Store byte addr=0x103, wdata=0xAB, zero-wait slave -> sel_o=1000, dat_o=0xABABABAB, adr_o=0x100, done_o at T+2.
REQ-032 Signed half load addr=0x102, memory word 0x8001_1234 -> sel_o=1100, rdata_o=0xFFFF8001 at T+3; with unsigned_i=1 -> 0x00008001.
REQ-033 Word load addr=0x006 -> no cyc_o, done_o and misalign_o at T+1.
REQ-034 Slave never acks, TIMEOUT=4 -> cyc_o high 4 cycles, then done_o with timeout_o=1, rdata_o=0.
REQ-035 ack_i in the same cycle the counter reaches TIMEOUT -> normal completion, timeout_o=0.
REQ-036 reset_n pulsed low during BUS -> cyc_o drops asynchronously, no done_o, next request completes normally.

Source files
------------

// File: rtl/lsu_wb_master.sv
// lsu_wb_master: load/store unit front end that turns single core memory
// requests into classic Wishbone single-beat cycles. It steers sub-word
// stores onto the correct byte lanes, extends sub-word loads, rejects
// misaligned accesses without touching the bus and aborts a bus cycle that
// the slave never acknowledges.
module lsu_wb_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    // core side
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        timeout_o,
    // Wishbone master side
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [3:0]  sel_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BUS   = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [8:0] TIMEOUT_LIMIT = 9'(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        unsigned_q, unsigned_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        timeout_q, timeout_d;

    logic        reqMisaligned;
    logic [3:0]  reqSel;
    logic [31:0] reqDat;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;
    logic [31:0] loadExt;
    logic [8:0]  cntNext;

    // Decode the incoming request: alignment check, lane enables and store-data replication
    always_comb begin
        reqMisaligned = 1'b0;
        reqSel        = 4'b1111;
        reqDat        = wdata_i;
        case (size_i)
            2'b00: begin
                reqSel = 4'b0001 << addr_i[1:0];
                reqDat = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                reqMisaligned = addr_i[0];
                reqSel        = 4'b0011 << {addr_i[1], 1'b0};
                reqDat        = {2{wdata_i[15:0]}};
            end
            default: begin
                reqMisaligned = (addr_i[1:0] != 2'b00);
            end
        endcase
    end

    // Pick the addressed lane out of the registered slave data and extend it to 32 bits
    always_comb begin
        byteLane = dat_i[{addr_q[1:0], 3'b000} +: 8];
        halfLane = dat_i[{addr_q[1], 4'b0000} +: 16];
        loadExt  = dat_i;
        case (size_q)
            2'b00:   loadExt = unsigned_q ? {24'h000000, byteLane} : {{24{byteLane[7]}}, byteLane};
            2'b01:   loadExt = unsigned_q ? {16'h0000, halfLane} : {{16{halfLane[15]}}, halfLane};
            default: loadExt = dat_i;
        endcase
    end

    assign cntNext = {1'b0, cnt_q} + 9'd1;

    // Transaction sequencer: accept, run the bus cycle, collect load data, report completion
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        we_d       = we_q;
        unsigned_d = unsigned_q;
        sel_d      = sel_q;
        dat_d      = dat_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    rdata_d   = 32'h0;
                    timeout_d = 1'b0;
                    if (reqMisaligned) begin
                        misalign_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        misalign_d = 1'b0;
                        addr_d     = addr_i;
                        size_d     = size_i;
                        we_d       = we_i;
                        unsigned_d = unsigned_i;
                        sel_d      = reqSel;
                        dat_d      = reqDat;
                        cnt_d      = 8'h00;
                        state_d    = S_BUS;
                    end
                end
            end
            S_BUS: begin
                if (ack_i) begin
                    state_d = we_q ? S_DONE : S_RDATA;
                end else begin
                    cnt_d = cntNext[7:0];
                    if (cntNext >= TIMEOUT_LIMIT) begin
                        timeout_d = 1'b1;
                        rdata_d   = 32'h0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_RDATA: begin
                rdata_d = loadExt;
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately whenever reset_n drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 32'h0;
            size_q     <= 2'b00;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            sel_q      <= 4'h0;
            dat_q      <= 32'h0;
            cnt_q      <= 8'h00;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            we_q       <= we_d;
            unsigned_q <= unsigned_d;
            sel_q      <= sel_d;
            dat_q      <= dat_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign cyc_o      = (state_q == S_BUS);
    assign stb_o      = (state_q == S_BUS);
    assign we_o       = we_q;
    assign adr_o      = {addr_q[31:2], 2'b00};
    assign sel_o      = (state_q == S_BUS) ? sel_q : 4'h0;
    assign dat_o      = dat_q;
    assign done_o     = (state_q == S_DONE);
    assign stall_o    = reset_n & (((state_q == S_IDLE) & req_i) | (state_q == S_BUS) | (state_q == S_RDATA));
    assign rdata_o    = rdata_q;
    assign misalign_o = misalign_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// tb_lsu_wb_master: drives core requests into lsu_wb_master, plays a small
// Wishbone slave memory with configurable wait states, and compares every
// completed transaction against a byte-level reference model.
module tb_lsu_wb_master;

    localparam int TMO = 4;

    logic        clk;
    logic        reset_n;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        misalign_o;
    logic        timeout_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i;

    int checkCount = 0;
    int passCount  = 0;

    // slaveMem is written through the DUT's bus outputs; refMem by the model's own rules
    logic [31:0] slaveMem [16];
    logic [31:0] refMem   [16];

    int          obsLatency;
    int          obsBus;
    logic [31:0] obsRdata;
    logic        obsMisalign;
    logic        obsTimeout;
    logic [3:0]  obsSel;
    logic [31:0] obsDat;
    logic [31:0] obsAdr;
    logic        obsWe;

    lsu_wb_master #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_i      (req_i),
        .we_i       (we_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .rdata_o    (rdata_o),
        .misalign_o (misalign_o),
        .timeout_o  (timeout_o),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .we_o       (we_o),
        .adr_o      (adr_o),
        .sel_o      (sel_o),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .ack_i      (ack_i)
    );

    // Free-running clock, rising edge is the active edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    endtask

    // Run one core request against the slave (waitCycles<0 means the slave never acks),
    // then compare what happened with what the reference model predicts
    task automatic applyStimulus(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input bit uns, input int waitCycles);
        int          nb;
        int          off;
        int          idx;
        int          pendingIdx;
        bit          mis;
        bit          expTo;
        int          expBus;
        int          expLat;
        logic [31:0] expSel;
        logic [31:0] expDat;
        logic [31:0] expRdata;
        logic [31:0] mask;
        bit          stallBad;
        bit          ackPending;
        logic [3:0]  doneSel;
        logic        doneAfter;

        // reference model: access width in bytes, lane offset, alignment and outcome
        nb       = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off      = int'(addr[1:0]) - (int'(addr[1:0]) % nb);
        mis      = (int'(addr[1:0]) % nb) != 0;
        idx      = int'(addr[5:2]);
        expSel   = ((32'd1 << nb) - 32'd1) << off;
        expRdata = 32'h0;
        expTo    = 1'b0;
        for (int i = 0; i < 4; i++) expDat[8*i +: 8] = wdata[8*(i % nb) +: 8];
        if (mis) begin
            expBus = 0;
            expLat = 1;
        end else if (waitCycles < 0 || waitCycles >= TMO) begin
            expBus = TMO;
            expLat = TMO + 1;
            expTo  = 1'b1;
        end else begin
            expBus = waitCycles + 1;
            expLat = expBus + (we ? 1 : 2);
            if (we) begin
                for (int i = off; i < off + nb; i++) refMem[idx][8*i +: 8] = wdata[8*(i - off) +: 8];
            end else begin
                mask     = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
                expRdata = (refMem[idx] >> (8*off)) & mask;
                if (!uns && nb < 4 && expRdata[8*nb-1]) expRdata = expRdata | ~mask;
            end
        end

        // drive the request and act as the slave cycle by cycle
        @(negedge clk);
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; size_i = size; unsigned_i = uns;
        ack_i = 1'b0; dat_i = $urandom;
        stallBad = 1'b0; ackPending = 1'b0; pendingIdx = 0;
        obsLatency = -1; obsBus = 0; obsSel = 4'h0; obsDat = 32'h0; obsAdr = 32'h0; obsWe = 1'b0;
        obsRdata = 32'h0; obsMisalign = 1'b0; obsTimeout = 1'b0; doneSel = 4'h0;
        #1;
        if (stall_o !== 1'b1) stallBad = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            ack_i = 1'b0;
            if (ackPending) begin
                dat_i = slaveMem[pendingIdx];
                ackPending = 1'b0;
            end else begin
                dat_i = $urandom;
            end
            if (done_o) begin
                obsLatency  = n;
                obsRdata    = rdata_o;
                obsMisalign = misalign_o;
                obsTimeout  = timeout_o;
                doneSel     = sel_o;
                if (stall_o !== 1'b0) stallBad = 1'b1;
                break;
            end
            if (stall_o !== 1'b1) stallBad = 1'b1;
            if (cyc_o) begin
                obsBus++;
                if (obsBus == 1) begin
                    obsSel = sel_o; obsDat = dat_o; obsAdr = adr_o; obsWe = we_o;
                end
                if (waitCycles >= 0 && obsBus == waitCycles + 1) begin
                    ack_i = 1'b1;
                    if (we_o) begin
                        for (int i = 0; i < 4; i++)
                            if (sel_o[i]) slaveMem[int'(adr_o[5:2])][8*i +: 8] = dat_o[8*i +: 8];
                    end else begin
                        ackPending = 1'b1;
                        pendingIdx = int'(adr_o[5:2]);
                    end
                end
            end
        end
        req_i = 1'b0;
        ack_i = 1'b0;
        @(negedge clk);
        doneAfter = done_o;

        checkOutput("latency",   32'(obsLatency), 32'(expLat));
        checkOutput("busCycles", 32'(obsBus), 32'(expBus));
        checkOutput("misalign",  32'(obsMisalign), 32'(mis));
        checkOutput("timeout",   32'(obsTimeout), 32'(expTo));
        checkOutput("stall",     32'(stallBad), 32'd0);
        checkOutput("selIdle",   32'(doneSel), 32'd0);
        checkOutput("donePulse", 32'(doneAfter), 32'd0);
        if (!mis) begin
            checkOutput("adr", obsAdr, {addr[31:2], 2'b00});
            checkOutput("sel", 32'(obsSel), expSel);
            checkOutput("we",  32'(obsWe), 32'(we));
            if (we) checkOutput("dat", obsDat, expDat);
            if (!we || expTo) checkOutput("rdata", obsRdata, expRdata);
        end
    endtask

    // Directed scenarios first, then a randomized run, then the summary
    initial begin
        logic [31:0] w;
        bit          sawDone;
        int          r;
        int          waitCycles;

        reset_n = 1'b0; req_i = 1'b0; we_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
        size_i = 2'b00; unsigned_i = 1'b0; ack_i = 1'b0; dat_i = 32'h0;
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            slaveMem[i] = w;
            refMem[i]   = w;
        end
        slaveMem[0] = 32'h8001_1234;
        refMem[0]   = 32'h8001_1234;

        repeat (3) @(negedge clk);
        checkOutput("rstCyc",      32'(cyc_o), 32'd0);
        checkOutput("rstStb",      32'(stb_o), 32'd0);
        checkOutput("rstWe",       32'(we_o), 32'd0);
        checkOutput("rstSel",      32'(sel_o), 32'd0);
        checkOutput("rstAdr",      adr_o, 32'd0);
        checkOutput("rstDat",      dat_o, 32'd0);
        checkOutput("rstRdata",    rdata_o, 32'd0);
        checkOutput("rstDone",     32'(done_o), 32'd0);
        checkOutput("rstStall",    32'(stall_o), 32'd0);
        checkOutput("rstMisalign", 32'(misalign_o), 32'd0);
        checkOutput("rstTimeout",  32'(timeout_o), 32'd0);
        reset_n = 1'b1;

        // signed and unsigned half loads from the upper half of 0x8001_1234
        applyStimulus(1'b0, 32'h0000_0102, 32'h0, 2'b01, 1'b0, 0);
        checkOutput("halfSigned", obsRdata, 32'hFFFF_8001);
        checkOutput("halfSel", 32'(obsSel), 32'h0000_000C);
        checkOutput("halfLat", 32'(obsLatency), 32'd3);
        applyStimulus(1'b0, 32'h0000_0102, 32'h0, 2'b01, 1'b1, 0);
        checkOutput("halfUnsigned", obsRdata, 32'h0000_8001);

        // byte store into the top lane
        applyStimulus(1'b1, 32'h0000_0103, 32'h0000_00AB, 2'b00, 1'b0, 0);
        checkOutput("byteSel", 32'(obsSel), 32'h0000_0008);
        checkOutput("byteDat", obsDat, 32'hABAB_ABAB);
        checkOutput("byteAdr", obsAdr, 32'h0000_0100);
        checkOutput("byteLat", 32'(obsLatency), 32'd2);

        // misaligned word load never reaches the bus
        applyStimulus(1'b0, 32'h0000_0006, 32'h0, 2'b10, 1'b0, 0);
        checkOutput("misLat", 32'(obsLatency), 32'd1);
        checkOutput("misFlag", 32'(obsMisalign), 32'd1);

        // silent slave, then an ack arriving exactly on the last allowed cycle
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 2'b10, 1'b0, -1);
        checkOutput("toFlag", 32'(obsTimeout), 32'd1);
        checkOutput("toRdata", obsRdata, 32'h0);
        checkOutput("toBus", 32'(obsBus), 32'(TMO));
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 2'b10, 1'b0, TMO - 1);
        checkOutput("lateAckTimeout", 32'(obsTimeout), 32'd0);

        // size 11 behaves as a word
        applyStimulus(1'b1, 32'h0000_0024, 32'hDEAD_BEEF, 2'b11, 1'b0, 1);
        applyStimulus(1'b0, 32'h0000_0024, 32'h0, 2'b11, 1'b1, 2);
        checkOutput("size3Load", obsRdata, 32'hDEAD_BEEF);

        // reset pulse in the middle of a bus cycle
        @(negedge clk);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0048; size_i = 2'b10; unsigned_i = 1'b0; ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("midBusCyc", 32'(cyc_o), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("asyncCyc",   32'(cyc_o), 32'd0);
        checkOutput("asyncStall", 32'(stall_o), 32'd0);
        checkOutput("asyncSel",   32'(sel_o), 32'd0);
        checkOutput("asyncAdr",   adr_o, 32'd0);
        req_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_o) sawDone = 1'b1;
        end
        checkOutput("noDoneAfterReset", 32'(sawDone), 32'd0);
        applyStimulus(1'b0, 32'h0000_0048, 32'h0, 2'b10, 1'b0, 1);

        // randomized mix of sizes, alignments, directions and slave wait behaviour
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            waitCycles = (r == 9) ? -1 : (r >= 7) ? TMO : (r == 6) ? TMO - 1 : (r % 3);
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), waitCycles);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
